// File: rtl/pilha_pkg.sv
// Shared definitions for the stack controller and the 64x16 stack memory.
//   LARGURA_PAD  default data word width (memory Largura_da_pilha)
//   TAMANHO_PAD  default stack depth in words (memory Tamanho_da_pilha)
//   END_W_PAD    default address width (memory Tamanho_endereco)
//   estado_t     controller state encoding
package pilha_pkg;

  localparam int LARGURA_PAD = 16;
  localparam int TAMANHO_PAD = 64;
  localparam int END_W_PAD   = 6;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESCRITA = 2'd1,
    LEITURA = 2'd2,
    CAPTURA = 2'd3
  } estado_t;

endpackage

// File: rtl/controle_pilha.sv
// controle_pilha: stack controller sitting directly upstream of the stack
// memory. Converts push/pop requests into address/direction sequences on the
// memory port, owns the stack pointer and full/empty status, and performs the
// tri-state turnaround on the shared data bus.
//
// A push takes one memory cycle (write captured at the following edge).
// A pop takes two memory cycles because the memory read is registered.
//
// Ports:
//   clk          rising-edge clock, shared with the memory
//   rst          asynchronous active-high reset
//   push, pop    level requests, held until accepted (accepted when ready=1)
//   dado_in      word to push, sampled at the acceptance edge
//   ready        controller idle
//   dado_out     last popped word, held until the next pop
//   dado_valido  one-cycle pulse when dado_out has just been updated
//   vazia/cheia  empty / full status
//   nivel        number of stored words, 0..TAMANHO
//   mem_end      memory address
//   mem_io       memory direction, 1 = controller drives the bus (write)
//   mem_dado     shared bidirectional memory data bus
//   erro_over    (PILHA_ERRO_EN only) sticky: push requested while full
//   erro_under   (PILHA_ERRO_EN only) sticky: pop requested while empty
//
// Build option: define PILHA_ERRO_EN to add the sticky error outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OCIOSO  | idle, ready=1, arbitrates requests (push before pop)
// ESCRITA | mem_io=1, memory captures the word at the next edge
// LEITURA | address presented, memory registers the word at next edge
// CAPTURA | memory output on the bus, captured into dado_out
module controle_pilha
  import pilha_pkg::*;
#(
  parameter int LARGURA = LARGURA_PAD,
  parameter int TAMANHO = TAMANHO_PAD,
  parameter int END_W   = END_W_PAD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [LARGURA-1:0] dado_in,
  output logic               ready,
  output logic [LARGURA-1:0] dado_out,
  output logic               dado_valido,
  output logic               vazia,
  output logic               cheia,
  output logic [END_W:0]     nivel,
  output logic [END_W-1:0]   mem_end,
  output logic               mem_io,
`ifdef PILHA_ERRO_EN
  output logic               erro_over,
  output logic               erro_under,
`endif
  inout  wire  [LARGURA-1:0] mem_dado
);

  localparam int NIVEL_W = END_W + 1;
  localparam logic [NIVEL_W-1:0] CHEIO = NIVEL_W'(TAMANHO);
  localparam logic [NIVEL_W-1:0] UM    = NIVEL_W'(1);

  estado_t              estado, estado_prox;
  logic [NIVEL_W-1:0]   sp, sp_prox;
  logic [NIVEL_W-1:0]   sp_menos;
  logic [END_W-1:0]     end_prox;
  logic                 io_prox;
  logic [LARGURA-1:0]   drive, drive_prox;
  logic [LARGURA-1:0]   saida_prox;
  logic                 valido_prox;

  assign nivel    = sp;
  assign vazia    = (sp == '0);
  assign cheia    = (sp == CHEIO);
  assign ready    = (estado == OCIOSO);
  assign sp_menos = sp - UM;

  // mem_io and drive come from the same register bank, so the controller
  // only ever drives the bus while the memory is in write direction.
  assign mem_dado = mem_io ? drive : {LARGURA{1'bz}};

  always_comb begin
    estado_prox = estado;
    sp_prox     = sp;
    end_prox    = mem_end;
    io_prox     = mem_io;
    drive_prox  = drive;
    saida_prox  = dado_out;
    valido_prox = 1'b0;
    case (estado)
      OCIOSO: begin
        if (push && !cheia) begin
          estado_prox = ESCRITA;
          end_prox    = sp[END_W-1:0];
          io_prox     = 1'b1;
          drive_prox  = dado_in;
        end else if (pop && !vazia) begin
          // push & cheia falls through here so a legal pop still proceeds
          estado_prox = LEITURA;
          end_prox    = sp_menos[END_W-1:0];
          io_prox     = 1'b0;
        end
      end
      ESCRITA: begin
        sp_prox     = sp + UM;
        io_prox     = 1'b0;
        estado_prox = OCIOSO;
      end
      LEITURA: begin
        sp_prox     = sp_menos;
        estado_prox = CAPTURA;
      end
      CAPTURA: begin
        saida_prox  = mem_dado;
        valido_prox = 1'b1;
        estado_prox = OCIOSO;
      end
      default: begin
        estado_prox = OCIOSO;
        io_prox     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= OCIOSO;
      sp          <= '0;
      mem_end     <= '0;
      mem_io      <= 1'b0;
      drive       <= '0;
      dado_out    <= '0;
      dado_valido <= 1'b0;
    end else begin
      estado      <= estado_prox;
      sp          <= sp_prox;
      mem_end     <= end_prox;
      mem_io      <= io_prox;
      drive       <= drive_prox;
      dado_out    <= saida_prox;
      dado_valido <= valido_prox;
    end
  end

`ifdef PILHA_ERRO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      erro_over  <= 1'b0;
      erro_under <= 1'b0;
    end else if (estado == OCIOSO) begin
      if (push && cheia) erro_over  <= 1'b1;
      if (pop && vazia)  erro_under <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_controle_pilha.sv
// Scoreboard bench for controle_pilha with a behavioural 64x16 stack memory
// (synchronous write, registered read).
module tb_controle_pilha;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] dado_in = '0;
  logic        ready;
  logic [15:0] dado_out;
  logic        dado_valido;
  logic        vazia;
  logic        cheia;
  logic [6:0]  nivel;
  logic [5:0]  mem_end;
  logic        mem_io;
  wire  [15:0] mem_dado;
`ifdef PILHA_ERRO_EN
  logic        erro_over;
  logic        erro_under;
`endif

  controle_pilha dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .dado_in(dado_in),
    .ready(ready), .dado_out(dado_out), .dado_valido(dado_valido),
    .vazia(vazia), .cheia(cheia), .nivel(nivel),
    .mem_end(mem_end), .mem_io(mem_io),
`ifdef PILHA_ERRO_EN
    .erro_over(erro_over), .erro_under(erro_under),
`endif
    .mem_dado(mem_dado)
  );

  always #5 clk = ~clk;

  // memory model
  logic [15:0] mem [64];
  logic [15:0] rd;
  always @(posedge clk) begin
    if (mem_io) mem[mem_end] <= mem_dado;
    rd <= mem[mem_end];
  end
  assign mem_dado = mem_io ? 16'bz : rd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int model_n = 0;

  logic [21:0] wrq [$];   // {addr, data}
  logic [47:0] rdq [$];   // {data, expected cycle}

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
    end
  endtask

  // write monitor: a cycle with mem_io=1 commits a word at the next edge
  always @(negedge clk) begin
    if (mem_io === 1'b1) begin
      if (wrq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h expected none", mem_end, mem_dado);
      end else begin
        logic [21:0] e;
        e = wrq.pop_front();
        check("write_addr", {26'd0, mem_end}, {26'd0, e[21:16]});
        check("write_data", {16'd0, mem_dado}, {16'd0, e[15:0]});
      end
    end
  end

  // read monitor: every dado_valido pulse consumes one expected pop
  always @(negedge clk) begin
    if (dado_valido === 1'b1) begin
      if (rdq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_valid: dado_out 0x%0h expected no pulse", dado_out);
      end else begin
        logic [47:0] e;
        e = rdq.pop_front();
        check("pop_data", {16'd0, dado_out}, {16'd0, e[47:32]});
        check("pop_latency", cyc, e[31:0]);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: ready %b expected 1", ready);
    end
  endtask

  task automatic do_push(input logic [15:0] d);
    @(negedge clk);
    push = 1'b1;
    dado_in = d;
    wait_ready();
    wrq.push_back({6'(model_n), d});
    @(posedge clk);
    #1 push = 1'b0;
    model_n++;
  endtask

  task automatic do_pop(input logic [15:0] d);
    @(negedge clk);
    pop = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 pop = 1'b0;
    rdq.push_back({d, 32'(cyc + 2)});
    model_n--;
  endtask

  task automatic drain();
    int n = 0;
    while ((rdq.size() != 0 || ready !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'd0, (rdq.size() == 0 && ready === 1'b1)}, 32'd1);
  endtask

  initial begin
    // reset values
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_vazia", {31'd0, vazia}, 32'd1);
    check("rst_cheia", {31'd0, cheia}, 32'd0);
    check("rst_nivel", {25'd0, nivel}, 32'd0);
    check("rst_mem_io", {31'd0, mem_io}, 32'd0);
    check("rst_mem_end", {26'd0, mem_end}, 32'd0);
    check("rst_dado_out", {16'd0, dado_out}, 32'd0);
    check("rst_valido", {31'd0, dado_valido}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // three pushes, ready low for exactly one cycle each
    for (int i = 1; i <= 3; i++) begin
      do_push(16'(i));
      @(negedge clk);
      check("push_busy", {31'd0, ready}, 32'd0);
      @(negedge clk);
      check("push_ready_back", {31'd0, ready}, 32'd1);
    end
    check("nivel3", {25'd0, nivel}, 32'd3);
    check("vazia3", {31'd0, vazia}, 32'd0);

    // three pops in LIFO order
    do_pop(16'h0003);
    do_pop(16'h0002);
    do_pop(16'h0001);
    drain();
    check("nivel0", {25'd0, nivel}, 32'd0);
    check("vazia0", {31'd0, vazia}, 32'd1);

    // pop while empty is dropped
    @(negedge clk);
    pop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("empty_pop_ready", {31'd0, ready}, 32'd1);
      check("empty_pop_io", {31'd0, mem_io}, 32'd0);
    end
    pop = 1'b0;
    check("empty_pop_nivel", {25'd0, nivel}, 32'd0);
`ifdef PILHA_ERRO_EN
    check("erro_under", {31'd0, erro_under}, 32'd1);
    check("erro_over_clear", {31'd0, erro_over}, 32'd0);
`endif

    // fill to capacity
    for (int i = 0; i < 64; i++) do_push(16'(i));
    @(negedge clk);
    @(negedge clk);
    check("full_cheia", {31'd0, cheia}, 32'd1);
    check("full_nivel", {25'd0, nivel}, 32'd64);

    // 65th push never accepted; a pop still proceeds while push is held
    push = 1'b1;
    dado_in = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      check("over_ready", {31'd0, ready}, 32'd1);
      check("over_nivel", {25'd0, nivel}, 32'd64);
    end
`ifdef PILHA_ERRO_EN
    check("erro_over", {31'd0, erro_over}, 32'd1);
`endif
    pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0;
    push = 1'b0;
    rdq.push_back({16'h003F, 32'(cyc + 2)});
    model_n--;
    drain();
    check("after_full_pop_nivel", {25'd0, nivel}, 32'd63);

    // fresh stack with one word 0x00AA, then simultaneous push/pop
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_n = 0;
    do_push(16'h00AA);
    @(negedge clk);
    push = 1'b1;
    pop = 1'b1;
    dado_in = 16'h0055;
    wait_ready();
    wrq.push_back({6'd1, 16'h0055});
    @(posedge clk);
    #1 push = 1'b0;
    model_n++;
    @(negedge clk);
    check("both_push_first", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("both_nivel2", {25'd0, nivel}, 32'd2);
    wait_ready();
    @(posedge clk);
    #1 pop = 1'b0;
    rdq.push_back({16'h0055, 32'(cyc + 2)});
    model_n--;
    drain();
    check("both_nivel1", {25'd0, nivel}, 32'd1);

    // reset while in ESCRITA aborts the write
    @(negedge clk);
    push = 1'b1;
    dado_in = 16'h0077;
    @(posedge clk);
    #1 push = 1'b0;
    check("escrita_io", {31'd0, mem_io}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_io", {31'd0, mem_io}, 32'd0);
    check("abort_nivel", {25'd0, nivel}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_valido", {31'd0, dado_valido}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_mem_kept", {16'd0, mem[1]}, 32'h0055);
    check("abort_dado_out", {16'd0, dado_out}, 32'd0);
`ifdef PILHA_ERRO_EN
    check("erro_cleared", {30'd0, erro_over, erro_under}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("wrq_empty", wrq.size(), 32'd0);
    check("rdq_empty", rdq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/controle_pilha.md
Name: controle_pilha

Overview:
- Stack controller that sits directly upstream of the 64x16 stack memory.
- Turns push/pop requests from the datapath into memory address and direction (io) sequences.
- Owns the stack pointer, full/empty status and the tri-state turnaround on the shared data bus.
- The memory's read is registered, so a pop costs two memory cycles; a push costs one.

Parameters:
- LARGURA, 16, data word width; equals the memory's Largura_da_pilha.
- TAMANHO, 64, stack depth in words; equals Tamanho_da_pilha.
- END_W, 6, address width; equals Tamanho_endereco; TAMANHO must be 2**END_W.

Ports:
- clk  in  1  rising-edge clock shared with the memory.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  push request, level; held until accepted.
- pop  in  1  pop request, level; held until accepted.
- dado_in  in  LARGURA  word to push; sampled at acceptance edge.
- ready  out  1  controller idle; a request is accepted on a posedge where ready=1.
- dado_out  out  LARGURA  last popped word; holds until the next pop.
- dado_valido  out  1  one-cycle pulse: dado_out newly updated.
- vazia  out  1  nivel==0.
- cheia  out  1  nivel==TAMANHO.
- nivel  out  END_W+1  words stored, 0..TAMANHO.
- mem_end  out  END_W  memory address (Endereco).
- mem_io  out  1  memory direction (io); 1=write, 0=memory drives the bus.
- mem_dado  inout  LARGURA  memory data bus (Data).

Behaviour:
- sp (END_W+1 bits) points to the next free slot, so nivel=sp. The top of stack is sp-1.
- Reset, asynchronous:
  - sp=0; state OCIOSO.
  - mem_io=0, mem_end=0; bus driver released (Z).
  - dado_out=0, dado_valido=0.
  - Giving ready=1, vazia=1, cheia=0, nivel=0.
- ready is 1 only in OCIOSO. mem_io, mem_end, the drive register, dado_out and dado_valido are all registered.
- mem_dado is driven with the drive register only while mem_io=1; otherwise it is Z. Both come from the same register, so there is no bus contention.
- States:
  - OCIOSO:
    - push & !cheia at posedge N -> ESCRITA; mem_end<=sp, mem_io<=1, drive<=dado_in.
    - Else pop & !vazia -> LEITURA; mem_end<=sp-1, mem_io<=0.
    - Push has priority when both are requested; the pop stays pending.
  - ESCRITA: the memory captures at N+1. At that edge sp<=sp+1, mem_io<=0, next state OCIOSO. Push latency is 1 cycle; nivel updates at N+1.
  - LEITURA: the memory registers wo at N+1. At that edge sp<=sp-1, next state CAPTURA.
  - CAPTURA: at N+2, dado_out<=mem_dado, dado_valido<=1 for one cycle, next state OCIOSO. Pop latency is 2 cycles; ready returns at N+2.
- Illegal requests (push & cheia, pop & vazia) are not accepted. State and sp are unchanged and ready stays 1. Alternation order lets a legal pop proceed when push & cheia.
- Wrap: sp never exceeds TAMANHO and never goes below 0. mem_end is the low END_W bits, so address 63 is the last slot.
- Reset mid-operation: everything returns to reset values immediately. mem_io drops to 0 asynchronously, so a write pending at the next edge is aborted. Memory contents are don't-care because sp=0.
- Requests asserted during reset are ignored until the first posedge after rst deasserts.

Optional Feature:
- Macro PILHA_ERRO_EN.
- Defined:
  - Extra outputs erro_over and erro_under (1 bit each).
  - Sticky: set on the first posedge with an illegal push (resp. pop) in OCIOSO.
  - Cleared only by rst.
- Not defined: the ports are absent and illegal requests are silently dropped.

Decomposition:
- Shared package pilha_pkg:
  - Default LARGURA/TAMANHO/END_W constants.
  - typedef enum estado_t {OCIOSO, ESCRITA, LEITURA, CAPTURA}.
- No sub-module needed; the tri-state bus driver stays inline (one continuous assign).
- The top level instantiates controle_pilha next to Pilha.

Test Plan:
- Reset then three pushes 0x0001, 0x0002, 0x0003:
  - Each push accepted, ready low for 1 cycle.
  - Memory addresses 0, 1, 2 written.
  - nivel=3, vazia=0.
- Three pops after the above:
  - dado_out 0x0003, 0x0002, 0x0001, each with a 1-cycle dado_valido 2 cycles after acceptance.
  - nivel ends 0, vazia=1.
- 64 pushes of value i:
  - cheia=1, nivel=64.
  - A 65th push is never accepted, ready stays 1, with PILHA_ERRO_EN erro_over=1.
  - A following pop returns 0x003F.
- Pop when empty after reset: no memory access, mem_io stays 0, nivel=0; with PILHA_ERRO_EN erro_under=1.
- push and pop both high with nivel=1 (top 0x00AA), dado_in=0x0055:
  - Push executes first (nivel=2).
  - The pending pop then returns 0x0055.
- rst asserted in ESCRITA:
  - mem_io drops to 0 before the next edge and that word is not written.
  - nivel=0, ready=1, dado_valido=0.
